lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Memory-mapped HD44780 character-LCD controller on the far side of the CPU's LCD output register. It consumes the 32-bit word the LSU drives on `io_lcd_o` and turns each software-posted command into a timed LCD bus write (setup, enable pulse, hold, execution wait). It runs the power-on initialisation sequence itself. A status word returns to the LSU input mux, so firmware polls `busy` instead of bit-banging enable timing.

## Interface
- `T_SETUP_CYC`, default 2: RS/data setup before EN rises, in cycles.
- `T_EN_CYC`, default 12: EN high time, in cycles.
- `T_HOLD_CYC`, default 2: RS/data hold after EN falls, in cycles.
- `T_EXEC_CYC`, default 1850: execution wait for a normal command or data write (37 us at 50 MHz).
- `T_CLEAR_CYC`, default 76000: execution wait for clear or home (1.52 ms).
- `T_PWRON_CYC`, default 2000000: wait after power-on before initialisation (40 ms).
- Reset is synchronous and active-low; one clock.
- `clk_i` in, 1 bit: system clock.
- `rst_ni` in, 1 bit: synchronous active-low reset.
- `lcd_cmd_i` in, 32 bits: the LCD register word from the LSU.
  - [7:0] data byte
  - [8] RS
  - [9] command tag (toggle)
  - [30] backlight
  - [31] power
  - other bits ignored
- `lcd_stat_o` out, 32 bits: status word.
  - [0] busy
  - [1] init_done
  - [2] last accepted tag
  - others 0
- `lcd_data_o` out, 8 bits: LCD DB7..DB0.
- `lcd_rs_o` out, 1 bit: register select.
- `lcd_rw_o` out, 1 bit: read/write; tied to 0 (write only).
- `lcd_en_o` out, 1 bit: enable strobe.
- `lcd_on_o` out, 1 bit: panel power.
- `lcd_blon_o` out, 1 bit: backlight.

## Operation
- **States:** PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC.
- **Reset values:**
  - state is PWR_WAIT.
  - All LCD outputs are 0.
  - Accepted tag is 0; init index is 0.
  - busy is 1; init_done is 0.
- **Power and backlight:** `lcd_on_o` and `lcd_blon_o` are registered copies of cmd[31] and cmd[30].
- **PWR_WAIT:**
  - Idles while cmd[31] is 0.
  - When cmd[31] is 1, counts T_PWRON_CYC cycles, then goes to INIT.
- **INIT:**
  - Issues ROM entry `idx` with RS=0, through SETUP/PULSE/HOLD/EXEC.
  - ROM contents in order: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - After the last entry's EXEC: set init_done=1, go to IDLE.
- **IDLE:**
  - busy is 0.
  - If cmd[9] differs from the accepted tag, accept the command at that edge:
    - latch data and RS onto the pins;
    - copy cmd[9] into the accepted tag;
    - set busy=1;
    - go to SETUP.
- **SETUP:** T_SETUP_CYC cycles, EN=0.
- **PULSE:** T_EN_CYC cycles, EN=1.
- **HOLD:** T_HOLD_CYC cycles, EN=0.
- **EXEC:**
  - Waits T_CLEAR_CYC if RS=0 and data is 0x01, 0x02 or 0x03; otherwise waits T_EXEC_CYC.
  - Then returns to IDLE, or to the next INIT step.
- Data and RS are stable from the acceptance edge until the exit from EXEC.
- **Tag changes while busy:** the tag is not sampled. A pending mismatch executes on the first IDLE cycle. Two toggles during one busy window cancel out, so nothing executes; firmware must poll busy.
- **Toggles during PWR_WAIT/INIT:** the command stays pending and executes after init.
- **Power drop:** cmd[31] falling in any state moves to PWR_WAIT at the next edge, with:
  - EN=0;
  - busy=1;
  - init_done=0;
  - init index cleared;
  - accepted tag kept.
- **Reset:** applies from any state, including mid-PULSE. EN drops at that edge.

## Timing
- Acceptance edge to busy falling: T_SETUP_CYC + T_EN_CYC + T_HOLD_CYC + T_EXEC_CYC (or T_CLEAR_CYC) cycles.
- EN rises T_SETUP_CYC cycles after acceptance and is high for exactly T_EN_CYC cycles.
- Minimum command spacing equals that latency plus 1 cycle (the IDLE sample).
- Busy rises in the same cycle the tag is accepted. There is no cycle where busy=0 while a mismatch is pending in IDLE and the command has not been accepted.
- Down counter width: $clog2(max of all timing parameters)+1.
  - Loaded with N-1 on state entry.
  - The state exits when the counter is 0.
  - A parameter value of 1 gives a 1-cycle state.

## Structure
- `lcd_pkg` holds:
  - the state enum;
  - command/status bit-position localparams;
  - the init ROM constant array and its length;
  - the clear/home opcode values.
- Sub-module `lcd_delay`: a loadable down counter with `load`, `value` and `done` ports. The FSM is the top.
- The CPU integrates by wiring `io_lcd_o` into `lcd_cmd_i` and `lcd_stat_o` into a spare LSU read address.

## Test plan
Bench parameters: T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_CLEAR=40, T_PWRON=20.
- Reset, then cmd=0x8000_0000 → EN stays 0 for 20 cycles. Then 7 EN pulses with data 38,38,38,38,0C,01,06. The 0x01 step gets a 40-cycle gap. init_done=1 when done, busy=0.
- After init, write 0x8000_0341 (RS=1, 'A', tag=1) → acceptance edge, EN high for cycles 3–6, busy=0 exactly 18 cycles after acceptance, stat[2]=1.
- Write clear 0x8000_0001 with tag toggled → busy lasts 2+4+2+40=48 cycles.
- Toggle tag during busy, once → the command executes on the first IDLE cycle. Toggle twice during busy → no second EN pulse.
- Drop cmd[31] mid-PULSE → next edge EN=0, busy=1, init_done=0. Re-raise it → full init repeats.
- Assert rst_ni=0 mid-EXEC for 1 cycle → all outputs return to reset values at that edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, bit positions and init ROM for the HD44780 controller
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC
  } lcd_state_e;

  localparam int CMD_RS_BIT    = 8;
  localparam int CMD_TAG_BIT   = 9;
  localparam int CMD_BL_BIT    = 30;
  localparam int CMD_PWR_BIT   = 31;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_INIT_BIT = 1;
  localparam int STAT_TAG_BIT  = 2;

  // Entry 0 sits in the low byte: 0x38 x4, 0x0C, 0x01, 0x06.
  localparam int INIT_LEN = 7;
  localparam logic [INIT_LEN*8-1:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38, 8'h38};

  localparam logic [7:0] OPC_CLEAR = 8'h01;
  localparam logic [7:0] OPC_HOME  = 8'h02;

  function automatic logic [7:0] init_entry(input logic [2:0] idx);
    return INIT_ROM[{idx, 3'b000} +: 8];
  endfunction

  // Home ignores bit 0, so 0x02 and 0x03 both take the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == OPC_CLEAR || data[7:1] == OPC_HOME[7:1]);
  endfunction

endpackage

// File: rtl/lcd_if.sv
// rtl/lcd_if.sv - HD44780 pin bundle between controller and panel
interface lcd_if;
  logic [7:0] data;
  logic       rs;
  logic       rw;
  logic       en;
  logic       on;
  logic       blon;

  modport master (output data, rs, rw, en, on, blon);
  modport slave  (input  data, rs, rw, en, on, blon);
endinterface

// File: rtl/lcd_delay.sv
// rtl/lcd_delay.sv - loadable down counter timing each controller state
module lcd_delay #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;

  // No reset of its own: the controller holds load high while in reset.
  always_ff @(posedge clk_i) begin
    if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - memory-mapped HD44780 controller: power-on init plus timed command writes
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 1850,
  parameter int T_CLEAR_CYC = 76000,
  parameter int T_PWRON_CYC = 2000000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  lcd_cmd_i,
  output logic [31:0]  lcd_stat_o,
  lcd_if.master        lcd
);
  localparam int T_M0  = (T_SETUP_CYC > T_EN_CYC) ? T_SETUP_CYC : T_EN_CYC;
  localparam int T_M1  = (T_M0 > T_HOLD_CYC) ? T_M0 : T_HOLD_CYC;
  localparam int T_M2  = (T_M1 > T_EXEC_CYC) ? T_M1 : T_EXEC_CYC;
  localparam int T_M3  = (T_M2 > T_CLEAR_CYC) ? T_M2 : T_CLEAR_CYC;
  localparam int T_MAX = (T_M3 > T_PWRON_CYC) ? T_M3 : T_PWRON_CYC;
  localparam int CW    = $clog2(T_MAX) + 1;

  lcd_state_e      state, state_n;
  logic            dly_load, dly_done;
  logic [CW-1:0]   dly_value;
  logic [7:0]      data_q;
  logic            rs_q, acc_tag, init_done, on_q, blon_q;
  logic [2:0]      init_idx;
  logic            busy, en;
  logic            pwr, tag_in, pending, last_step;
  logic            unused_cmd_bits;

  assign pwr             = lcd_cmd_i[CMD_PWR_BIT];
  assign tag_in          = lcd_cmd_i[CMD_TAG_BIT];
  assign pending         = (tag_in != acc_tag);
  assign last_step       = (init_idx == 3'(INIT_LEN - 1));
  assign unused_cmd_bits = ^lcd_cmd_i[29:10];

  lcd_delay #(.W(CW)) u_delay (
    .clk_i (clk_i),
    .load  (dly_load),
    .value (dly_value),
    .done  (dly_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= PWR_WAIT;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!pwr) begin
      state_n = PWR_WAIT;
    end else begin
      unique case (state)
        PWR_WAIT: if (dly_done) state_n = INIT;
        INIT:     state_n = SETUP;
        IDLE:     if (pending) state_n = SETUP;
        SETUP:    if (dly_done) state_n = PULSE;
        PULSE:    if (dly_done) state_n = HOLD;
        HOLD:     if (dly_done) state_n = EXEC;
        EXEC:     if (dly_done) state_n = (init_done || last_step) ? IDLE : INIT;
        default:  state_n = PWR_WAIT;
      endcase
    end
  end

  // busy includes a pending tag so software never sees an idle gap before acceptance.
  always_comb begin
    busy      = (state != IDLE) || pending;
    en        = (state == PULSE);
    dly_load  = !rst_ni || (state_n != state) || (state == PWR_WAIT && !pwr);
    dly_value = '0;
    if (!rst_ni || state_n == PWR_WAIT) begin
      dly_value = CW'(T_PWRON_CYC - 1);
    end else begin
      unique case (state_n)
        SETUP:   dly_value = CW'(T_SETUP_CYC - 1);
        PULSE:   dly_value = CW'(T_EN_CYC - 1);
        HOLD:    dly_value = CW'(T_HOLD_CYC - 1);
        EXEC:    dly_value = is_slow_cmd(rs_q, data_q) ? CW'(T_CLEAR_CYC - 1)
                                                       : CW'(T_EXEC_CYC - 1);
        default: dly_value = '0;
      endcase
    end
    lcd_stat_o                = '0;
    lcd_stat_o[STAT_BUSY_BIT] = busy;
    lcd_stat_o[STAT_INIT_BIT] = init_done;
    lcd_stat_o[STAT_TAG_BIT]  = acc_tag;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q    <= '0;
      rs_q      <= 1'b0;
      acc_tag   <= 1'b0;
      init_idx  <= '0;
      init_done <= 1'b0;
      on_q      <= 1'b0;
      blon_q    <= 1'b0;
    end else begin
      on_q   <= pwr;
      blon_q <= lcd_cmd_i[CMD_BL_BIT];
      if (!pwr) begin
        init_done <= 1'b0;
        init_idx  <= '0;
      end else begin
        if (state == INIT) begin
          data_q <= init_entry(init_idx);
          rs_q   <= 1'b0;
        end
        if (state == IDLE && pending) begin
          data_q  <= lcd_cmd_i[7:0];
          rs_q    <= lcd_cmd_i[CMD_RS_BIT];
          acc_tag <= tag_in;
        end
        if (state == EXEC && dly_done && !init_done) begin
          if (last_step) init_done <= 1'b1;
          else           init_idx  <= init_idx + 3'd1;
        end
      end
    end
  end

  assign lcd.data = data_q;
  assign lcd.rs   = rs_q;
  assign lcd.rw   = 1'b0;
  assign lcd.en   = en;
  assign lcd.on   = on_q;
  assign lcd.blon = blon_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - randomized self-checking bench for lcd_ctrl against a transaction-level model
module tb_lcd_ctrl;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 10;
  localparam int T_CLEAR = 40;
  localparam int T_PWRON = 20;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] lcd_cmd;
  logic [31:0] lcd_stat;

  lcd_if lcd_bus();

  lcd_ctrl #(
    .T_SETUP_CYC (T_SETUP),
    .T_EN_CYC    (T_EN),
    .T_HOLD_CYC  (T_HOLD),
    .T_EXEC_CYC  (T_EXEC),
    .T_CLEAR_CYC (T_CLEAR),
    .T_PWRON_CYC (T_PWRON)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .lcd_cmd_i  (lcd_cmd),
    .lcd_stat_o (lcd_stat),
    .lcd        (lcd_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         rise;
    int         width;
    logic [7:0] data;
    logic       rs;
  } pulse_t;

  pulse_t     pulses[$];
  logic       en_prev = 1'b0;
  int         rise_c;
  logic [7:0] rise_d;
  logic       rise_rs;

  always @(negedge clk) begin
    if (lcd_bus.en === 1'b1 && !en_prev) begin
      rise_c  = cyc;
      rise_d  = lcd_bus.data;
      rise_rs = lcd_bus.rs;
    end
    if (lcd_bus.en === 1'b0 && en_prev)
      pulses.push_back('{rise_c, cyc - rise_c, rise_d, rise_rs});
    en_prev = (lcd_bus.en === 1'b1);
  end

  int checks = 0;
  int failures = 0;
  logic       tag_m;
  logic       bl;
  logic [7:0] rom [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] make_cmd(input logic p, input logic b, input logic t,
                                           input logic rs, input logic [7:0] d);
    return {p, b, 20'b0, t, rs, d};
  endfunction

  function automatic int exec_of(input logic [7:0] d, input logic rs);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_CLEAR : T_EXEC;
  endfunction

  function automatic int lat_of(input logic [7:0] d, input logic rs);
    return T_SETUP + T_EN + T_HOLD + exec_of(d, rs);
  endfunction

  task automatic wait_pulse(output pulse_t p);
    int n = 0;
    while (pulses.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    if (pulses.size() == 0) begin
      check("pulse_timeout", 32'd0, 32'd1);
      p = '{0, 0, 8'h00, 1'b0};
    end else begin
      p = pulses.pop_front();
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (lcd_stat[0] && n < 400) begin
      tick();
      n++;
    end
  endtask

  // PWR_WAIT spans T_PWRON cycles from p0, one cycle fetches a ROM entry, then setup.
  task automatic run_init(input int p0);
    pulse_t p;
    int exp_rise = p0 + T_PWRON + T_SETUP;
    int last_rise = exp_rise;
    int done_c;
    for (int i = 0; i < 7; i++) begin
      wait_pulse(p);
      check($sformatf("init%0d_rise", i), p.rise, exp_rise);
      check($sformatf("init%0d_data", i), {24'b0, p.data}, {24'b0, rom[i]});
      check($sformatf("init%0d_rs", i), {31'b0, p.rs}, 32'd0);
      check($sformatf("init%0d_width", i), p.width, T_EN);
      last_rise = exp_rise;
      exp_rise  = exp_rise + T_EN + T_HOLD + exec_of(rom[i], 1'b0) + 1 + T_SETUP;
    end
    done_c = last_rise + T_EN + T_HOLD + exec_of(rom[6], 1'b0);
    while (cyc < done_c - 1) tick();
    check("init_busy_tail", {31'b0, lcd_stat[0]}, 32'd1);
    tick();
    check("init_done_stat", lcd_stat, {29'b0, tag_m, 2'b10});
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic rs);
    pulse_t p;
    int a, n;
    tag_m   = ~tag_m;
    bl      = 1'($urandom_range(0, 1));
    lcd_cmd = make_cmd(1'b1, bl, tag_m, rs, d);
    #1;
    check("pending_busy", {31'b0, lcd_stat[0]}, 32'd1);
    tick();
    a = cyc;
    check("acc_tag", {31'b0, lcd_stat[2]}, {31'b0, tag_m});
    wait_idle(n);
    check($sformatf("latency_%0h_%0d", d, rs), cyc - a, lat_of(d, rs));
    wait_pulse(p);
    check("cmd_rise", p.rise, a + T_SETUP);
    check("cmd_width", p.width, T_EN);
    check("cmd_data", {24'b0, p.data}, {24'b0, d});
    check("cmd_rs", {31'b0, p.rs}, {31'b0, rs});
    check("cmd_blon", {31'b0, lcd_bus.blon}, {31'b0, bl});
    check("cmd_on", {31'b0, lcd_bus.on}, 32'd1);
  endtask

  task automatic toggle_during_busy(input int toggles);
    pulse_t p;
    int a, n, l1, l2, k1, k2;
    logic [7:0] d1, d2;
    logic rs2;
    d1  = 8'($urandom);
    d2  = 8'($urandom);
    rs2 = 1'($urandom_range(0, 1));
    l1  = lat_of(d1, 1'b1);
    l2  = lat_of(d2, rs2);
    tag_m   = ~tag_m;
    lcd_cmd = make_cmd(1'b1, bl, tag_m, 1'b1, d1);
    tick();
    a  = cyc;
    k1 = $urandom_range(1, l1 - 3);
    k2 = $urandom_range(k1 + 1, l1 - 2);
    while (cyc < a + k1) tick();
    tag_m   = ~tag_m;
    lcd_cmd = make_cmd(1'b1, bl, tag_m, rs2, d2);
    if (toggles == 2) begin
      while (cyc < a + k2) tick();
      tag_m   = ~tag_m;
      lcd_cmd = make_cmd(1'b1, bl, tag_m, rs2, d2);
    end
    wait_idle(n);
    wait_pulse(p);
    check("tgl_first_rise", p.rise, a + T_SETUP);
    check("tgl_first_data", {24'b0, p.data}, {24'b0, d1});
    if (toggles == 1) begin
      check("chain_latency", cyc - a, l1 + 1 + l2);
      wait_pulse(p);
      check("chain_rise", p.rise, a + l1 + 1 + T_SETUP);
      check("chain_data", {24'b0, p.data}, {24'b0, d2});
      check("chain_rs", {31'b0, p.rs}, {31'b0, rs2});
    end else begin
      check("cancel_latency", cyc - a, l1);
      repeat (30) tick();
      check("cancel_no_pulse", pulses.size(), 0);
      check("cancel_idle", lcd_stat, {29'b0, tag_m, 2'b10});
    end
  endtask

  initial begin
    int a, p0;
    logic [7:0] d;
    logic rs;
    tag_m   = 1'b0;
    bl      = 1'b0;
    rst_ni  = 1'b0;
    lcd_cmd = 32'h8000_0000;
    tick();
    tick();
    check("rst_stat", lcd_stat, 32'd1);
    check("rst_pins", {lcd_bus.data, lcd_bus.rs, lcd_bus.rw, lcd_bus.en, lcd_bus.on, lcd_bus.blon}, 32'd0);
    rst_ni = 1'b1;
    tick();
    p0 = cyc;
    run_init(p0);

    send_cmd(8'h41, 1'b1);
    send_cmd(8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d  = 8'($urandom_range(1, 3));
        rs = 1'b0;
      end else begin
        d  = 8'($urandom);
        rs = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 3)) tick();
      send_cmd(d, rs);
    end

    toggle_during_busy(1);
    toggle_during_busy(2);

    // Power drop while EN is high.
    tag_m   = ~tag_m;
    lcd_cmd = make_cmd(1'b1, bl, tag_m, 1'b1, 8'h55);
    tick();
    a = cyc;
    while (cyc < a + T_SETUP + 1) tick();
    check("drop_en_before", {31'b0, lcd_bus.en}, 32'd1);
    lcd_cmd[31] = 1'b0;
    tick();
    check("drop_en", {31'b0, lcd_bus.en}, 32'd0);
    check("drop_stat", lcd_stat, {29'b0, tag_m, 2'b01});
    check("drop_on", {31'b0, lcd_bus.on}, 32'd0);
    repeat (3) tick();
    pulses.delete();
    lcd_cmd[31] = 1'b1;
    tick();
    p0 = cyc;
    run_init(p0);
    send_cmd(8'h02, 1'b0);

    // Reset pulse in the middle of EXEC.
    tag_m   = ~tag_m;
    lcd_cmd = make_cmd(1'b1, 1'b1, tag_m, 1'b1, 8'h7E);
    tick();
    a = cyc;
    while (cyc < a + T_SETUP + T_EN + T_HOLD + 3) tick();
    rst_ni  = 1'b0;
    tag_m   = 1'b0;
    lcd_cmd = make_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("rst_exec_stat", lcd_stat, 32'd1);
    check("rst_exec_pins", {lcd_bus.data, lcd_bus.rs, lcd_bus.rw, lcd_bus.en, lcd_bus.on, lcd_bus.blon}, 32'd0);
    pulses.delete();
    rst_ni = 1'b1;
    tick();
    p0 = cyc;
    run_init(p0);
    send_cmd(8'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end
endmodule
